core_bus_responder: RTL and testbench

- Memory-side responder for the `core` external bus. It consumes ADDR_BUF, DOUT_BUF, RDN_BUF, WRN0_BUF, WRN1_BUF and ABUS_OEN, and returns DIN, INT0 and INT1.
- Decodes two regions: a word RAM (program and data) and a small memory-mapped I/O block holding a down-counting timer and a software interrupt register.
- Replaces hand-driven DIN in core-level benches and is the memory for FPGA bring-up.

---
 rtl/core_bus_pkg.sv | 29 ++
 rtl/core_bus_timer.sv | 83 ++++++++
 rtl/core_bus_responder.sv | 100 ++++++++++
 tb/tb_core_bus_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/core_bus_pkg.sv
// Shared constants for the core bus responder: I/O register map, timer
// control/status bit positions and the byte-lane merge helper.
package core_bus_pkg;

  localparam logic [15:0] DEFAULT_IO_BASE = 16'hFF00;

  localparam logic [7:0] REG_LOAD   = 8'h00;
  localparam logic [7:0] REG_COUNT  = 8'h02;
  localparam logic [7:0] REG_CTRL   = 8'h04;
  localparam logic [7:0] REG_STATUS = 8'h06;
  localparam logic [7:0] REG_SWINT  = 8'h08;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IE    = 2;
  localparam int STATUS_EXP = 0;

  // lanes[0] selects bits [7:0], lanes[1] selects bits [15:8]
  function automatic logic [15:0] merge_lanes(input logic [15:0] old_val,
                                              input logic [15:0] new_val,
                                              input logic [1:0]  lanes);
    logic [15:0] result;
    result = old_val;
    if (lanes[0]) result[7:0]  = new_val[7:0];
    if (lanes[1]) result[15:8] = new_val[15:8];
    return result;
  endfunction

endpackage

// File: rtl/core_bus_timer.sv
// Down-counting timer behind the I/O window: LOAD/COUNT/CTRL/STATUS registers,
// byte-lane write port, combinational read mux and the INT0 request flop.
module bus_timer
  import core_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  wr_lanes,
  input  logic [7:0]  reg_off,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        int0
);

  logic [15:0] load_q, load_d;
  logic [15:0] count_q, count_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        exp_q, exp_d;
  logic        en_rise;
  logic        exp_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q  <= '0;
      count_q <= '0;
      ctrl_q  <= '0;
      exp_q   <= 1'b0;
      int0    <= 1'b0;
    end else begin
      load_q  <= load_d;
      count_q <= count_d;
      ctrl_q  <= ctrl_d;
      exp_q   <= exp_d;
      int0    <= exp_q & ctrl_q[CTRL_IE];
    end
  end

  // Bus writes first, then the timer tick; an expiry set overrides a
  // same-edge W1C, and a new LOAD only reaches COUNT on a later reload.
  always_comb begin
    load_d  = load_q;
    count_d = count_q;
    ctrl_d  = ctrl_q;
    exp_d   = exp_q;

    if (wr_en && reg_off == REG_LOAD)
      load_d = merge_lanes(load_q, wr_data, wr_lanes);
    if (wr_en && reg_off == REG_CTRL && wr_lanes[0])
      ctrl_d = wr_data[2:0];

    en_rise = ctrl_d[CTRL_EN] && !ctrl_q[CTRL_EN];
    exp_clr = wr_en && reg_off == REG_STATUS && wr_lanes[0] && wr_data[STATUS_EXP];
    if (exp_clr)
      exp_d = 1'b0;

    if (en_rise) begin
      count_d = load_q;
    end else if (ctrl_q[CTRL_EN]) begin
      if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end else begin
        exp_d = 1'b1;
        if (ctrl_q[CTRL_AUTO])
          count_d = load_q;
        else
          ctrl_d[CTRL_EN] = 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_off)
      REG_LOAD:   rd_data = load_q;
      REG_COUNT:  rd_data = count_q;
      REG_CTRL:   rd_data = {13'd0, ctrl_q};
      REG_STATUS: rd_data = {15'd0, exp_q};
      default:    rd_data = '0;
    endcase
  end

endmodule

// File: rtl/core_bus_responder.sv
// Memory-side responder for the core external bus: inline word RAM below
// IO_BASE, timer and software interrupt register above it, registered DIN.
module core_bus_responder
  import core_bus_pkg::*;
#(
  parameter int          AW        = 12,
  parameter logic [15:0] IO_BASE   = DEFAULT_IO_BASE,
  parameter              INIT_FILE = ""
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] ADDR_BUF,
  input  logic [15:0] DOUT_BUF,
  input  logic        RDN_BUF,
  input  logic        WRN0_BUF,
  input  logic        WRN1_BUF,
  input  logic        ABUS_OEN,
  output logic [15:0] DIN,
  output logic        INT0,
  output logic        INT1
);

  localparam int DEPTH = 1 << AW;

  logic [15:0]   ram [0:DEPTH-1];
  logic [AW-1:0] ram_idx;
  logic [15:0]   ram_rdata;
  logic [1:0]    wr_lanes;
  logic          bus_valid;
  logic          bus_wr;
  logic          bus_rd;
  logic          is_io;
  logic [15:0]   io_off;
  logic          io_hit;
  logic [15:0]   timer_rdata;
  logic [15:0]   rd_data;
  logic          swint_q;

  assign bus_valid = !ABUS_OEN;
  assign wr_lanes  = {!WRN1_BUF, !WRN0_BUF};
  assign bus_wr    = bus_valid && (wr_lanes != 2'b00);
  assign bus_rd    = bus_valid && !RDN_BUF && !bus_wr;

  assign is_io   = ADDR_BUF >= IO_BASE;
  assign io_off  = {ADDR_BUF[15:1], 1'b0} - IO_BASE;
  assign io_hit  = is_io && (io_off[15:8] == 8'd0);
  assign ram_idx = ADDR_BUF[AW:1];

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = 16'd0;
  end

  // No reset on the array so it maps to block RAM; RESET still blocks the write.
  always_ff @(posedge CLK) begin
    if (bus_wr && !is_io && !RESET) begin
      if (wr_lanes[0]) ram[ram_idx][7:0]  <= DOUT_BUF[7:0];
      if (wr_lanes[1]) ram[ram_idx][15:8] <= DOUT_BUF[15:8];
    end
  end

  assign ram_rdata = ram[ram_idx];

  bus_timer u_timer (
    .clk      (CLK),
    .rst      (RESET),
    .wr_en    (bus_wr && io_hit),
    .wr_lanes (wr_lanes),
    .reg_off  (io_off[7:0]),
    .wr_data  (DOUT_BUF),
    .rd_data  (timer_rdata),
    .int0     (INT0)
  );

  always_comb begin
    rd_data = ram_rdata;
    if (is_io) begin
      if (!io_hit)
        rd_data = '0;
      else if (io_off[7:0] == REG_SWINT)
        rd_data = {15'd0, swint_q};
      else
        rd_data = timer_rdata;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      DIN     <= '0;
      swint_q <= 1'b0;
    end else begin
      if (bus_rd)
        DIN <= rd_data;
      if (bus_wr && io_hit && io_off[7:0] == REG_SWINT && wr_lanes[0])
        swint_q <= DOUT_BUF[0];
    end
  end

  assign INT1 = swint_q;

endmodule

// File: tb/tb_core_bus_responder.sv
// Directed self-checking bench for core_bus_responder: RAM, byte lanes, bus
// gating, timer one-shot/auto-reload, W1C collision, async reset and SWINT.
module tb_core_bus_responder;

  logic        clk;
  logic        reset;
  logic [15:0] addr_buf;
  logic [15:0] dout_buf;
  logic        rdn_buf;
  logic        wrn0_buf;
  logic        wrn1_buf;
  logic        abus_oen;
  logic [15:0] din;
  logic        int0;
  logic        int1;

  int checks_total  = 0;
  int checks_passed = 0;

  core_bus_responder dut (
    .CLK      (clk),
    .RESET    (reset),
    .ADDR_BUF (addr_buf),
    .DOUT_BUF (dout_buf),
    .RDN_BUF  (rdn_buf),
    .WRN0_BUF (wrn0_buf),
    .WRN1_BUF (wrn1_buf),
    .ABUS_OEN (abus_oen),
    .DIN      (din),
    .INT0     (int0),
    .INT1     (int1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks_total++;
    if (actual === expected)
      checks_passed++;
    else
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
  endtask

  // Drives one bus cycle on the falling edge; returns just after the sampling edge.
  task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] data,
                               input logic rdn, input logic wrn0,
                               input logic wrn1, input logic oen);
    @(negedge clk);
    addr_buf = addr;
    dout_buf = data;
    rdn_buf  = rdn;
    wrn0_buf = wrn0;
    wrn1_buf = wrn1;
    abus_oen = oen;
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [15:0] addr, input logic [15:0] data,
                          input logic wrn0, input logic wrn1);
    applyStimulus(addr, data, 1'b1, wrn0, wrn1, 1'b0);
  endtask

  task automatic busRead(input logic [15:0] addr);
    applyStimulus(addr, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic busIdle();
    applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    reset    = 1'b1;
    addr_buf = 16'h0000;
    dout_buf = 16'h0000;
    rdn_buf  = 1'b1;
    wrn0_buf = 1'b1;
    wrn1_buf = 1'b1;
    abus_oen = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_din",  din, 16'h0000);
    checkOutput("reset_int0", {15'd0, int0}, 16'h0000);
    checkOutput("reset_int1", {15'd0, int1}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    busWrite(16'h0010, 16'h1234, 1'b0, 1'b0);
    checkOutput("ram_write_din_hold", din, 16'h0000);
    busRead(16'h0010);
    checkOutput("ram_read", din, 16'h1234);

    busWrite(16'h0020, 16'hAAAA, 1'b0, 1'b0);
    busWrite(16'h0020, 16'h5566, 1'b1, 1'b0);
    busRead(16'h0020);
    checkOutput("lane_high", din, 16'h55AA);
    busWrite(16'h0020, 16'h0077, 1'b0, 1'b1);
    busRead(16'h0020);
    checkOutput("lane_low", din, 16'h5577);

    applyStimulus(16'h0010, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("gated_din_hold", din, 16'h5577);
    busRead(16'h0010);
    checkOutput("gated_ram_kept", din, 16'h1234);

    applyStimulus(16'h0030, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rw_collision_din_hold", din, 16'h1234);
    busRead(16'h0030);
    checkOutput("rw_collision_write", din, 16'hBEEF);

    busRead(16'h2010);
    checkOutput("ram_alias", din, 16'h1234);
    busRead(16'hFF20);
    checkOutput("io_unmapped", din, 16'h0000);

    busWrite(16'hFF00, 16'hABCD, 1'b0, 1'b0);
    busWrite(16'hFF00, 16'h0012, 1'b0, 1'b1);
    busRead(16'hFF00);
    checkOutput("load_lane_low", din, 16'hAB12);
    busWrite(16'hFF02, 16'hFFFF, 1'b0, 1'b0);
    busRead(16'hFF02);
    checkOutput("count_readonly", din, 16'h0000);

    // One-shot: COUNT reads 3,2,1,0 then EXP, EN drops, INT0 follows.
    busWrite(16'hFF00, 16'h0003, 1'b0, 1'b0);
    busWrite(16'hFF04, 16'h0005, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      busRead(16'hFF02);
      checkOutput("oneshot_count", din, 16'(3 - i));
    end
    checkOutput("oneshot_int0_before", {15'd0, int0}, 16'h0000);
    busRead(16'hFF06);
    checkOutput("oneshot_exp", din, 16'h0001);
    checkOutput("oneshot_int0", {15'd0, int0}, 16'h0001);
    busRead(16'hFF04);
    checkOutput("oneshot_en_clear", din, 16'h0004);
    busWrite(16'hFF06, 16'h0001, 1'b0, 1'b0);
    checkOutput("w1c_int0_lag", {15'd0, int0}, 16'h0001);
    busIdle();
    checkOutput("w1c_int0_clear", {15'd0, int0}, 16'h0000);
    busRead(16'hFF06);
    checkOutput("w1c_exp_clear", din, 16'h0000);

    // Auto-reload with LOAD=1: EXP sets on every second edge.
    busWrite(16'hFF00, 16'h0001, 1'b0, 1'b0);
    busWrite(16'hFF04, 16'h0007, 1'b0, 1'b0);
    busIdle();
    busIdle();
    busWrite(16'hFF06, 16'h0001, 1'b0, 1'b0);
    checkOutput("auto_int0_first", {15'd0, int0}, 16'h0001);
    busWrite(16'hFF06, 16'h0001, 1'b0, 1'b0);
    checkOutput("auto_cleared_between", {15'd0, int0}, 16'h0000);
    busRead(16'hFF06);
    checkOutput("collision_set_wins", din, 16'h0001);
    checkOutput("collision_int0", {15'd0, int0}, 16'h0001);
    busWrite(16'hFF04, 16'h0000, 1'b0, 1'b0);

    busWrite(16'hFF08, 16'h0001, 1'b0, 1'b0);
    busIdle();
    checkOutput("swint_int1", {15'd0, int1}, 16'h0001);
    busWrite(16'hFF00, 16'h0005, 1'b0, 1'b0);
    busWrite(16'hFF04, 16'h0007, 1'b0, 1'b0);
    repeat (8) busIdle();
    checkOutput("running_int0", {15'd0, int0}, 16'h0001);
    busRead(16'h0010);
    checkOutput("pre_reset_din", din, 16'h1234);

    abus_oen = 1'b1;
    rdn_buf  = 1'b1;
    wrn0_buf = 1'b1;
    wrn1_buf = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_din",  din, 16'h0000);
    checkOutput("async_reset_int0", {15'd0, int0}, 16'h0000);
    checkOutput("async_reset_int1", {15'd0, int1}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    busRead(16'hFF02);
    checkOutput("reset_count", din, 16'h0000);
    busRead(16'hFF04);
    checkOutput("reset_ctrl", din, 16'h0000);
    busRead(16'h0010);
    checkOutput("reset_ram_kept", din, 16'h1234);
    busRead(16'hFF08);
    checkOutput("reset_swint", din, 16'h0000);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
